// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding-select generation for the F/D/E/M/W core.
// Keeps E/M/W shadows of each in-flight producer (dest, result kind, Tnew)
// and compares them with the D-stage sources and their Tuse.
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_A3,
    input  logic [1:0] D_Tnew,
    input  logic [1:0] D_Kind,
    output logic       stall,
    output logic [2:0] MFRD1D,
    output logic [2:0] MFRD2D,
    output logic [2:0] MFALUAE,
    output logic [2:0] MFALUBE,
    output logic [2:0] MFWDM
);

    localparam logic [1:0] K_ALU = 2'd0;
    localparam logic [1:0] K_MEM = 2'd1;
    localparam logic [1:0] K_PC8 = 2'd2;

    // E shadow
    logic [4:0] r_E_A3, r_E_rs, r_E_rt;
    logic [1:0] r_E_Tnew, r_E_Kind;
    // M shadow
    logic [4:0] r_M_A3, r_M_rt;
    logic [1:0] r_M_Tnew, r_M_Kind;
    // W shadow
    logic [4:0] r_W_A3;
    logic [1:0] r_W_Kind;

    logic [1:0] w_E_Tnew_dec;
    logic       w_stall;

    // Register 0 is hard-wired, so it can never be a forwarding/stall source.
    function automatic logic f_hit(input logic [4:0] src, input logic [4:0] a3);
        return (src != 5'd0) && (src == a3);
    endfunction

    // Hazard for one D source: a producer in E or M still too far from ready.
    // Tuse = 3 can never be exceeded by a 2-bit Tnew, so unused sources never stall.
    function automatic logic f_hz(input logic [4:0] src, input logic [1:0] tuse,
                                  input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                  input logic [4:0] m_a3, input logic [1:0] m_tnew);
        return (f_hit(src, e_a3) && (e_tnew > tuse)) ||
               (f_hit(src, m_a3) && (m_tnew > tuse));
    endfunction

    // D-stage select: youngest matching producer decides; a matching producer
    // that cannot supply a value yet yields 000 and the stall covers it.
    function automatic logic [2:0] f_dfwd(input logic [4:0] src,
                                          input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                          input logic [1:0] e_kind,
                                          input logic [4:0] m_a3, input logic [1:0] m_tnew,
                                          input logic [1:0] m_kind,
                                          input logic [4:0] w_a3, input logic [1:0] w_kind);
        logic [2:0] sel;
        sel = 3'b000;
        if (f_hit(src, e_a3)) begin
            if (e_kind == K_PC8 && e_tnew == 2'd0) sel = 3'b110;
        end else if (f_hit(src, m_a3)) begin
            if (m_kind == K_PC8)                         sel = 3'b101;
            else if (m_kind == K_ALU && m_tnew == 2'd0)  sel = 3'b100;
        end else if (f_hit(src, w_a3)) begin
            if (w_kind == K_PC8)      sel = 3'b011;
            else if (w_kind == K_MEM) sel = 3'b010;
            else if (w_kind == K_ALU) sel = 3'b001;
        end
        return sel;
    endfunction

    // E-stage select: ALU/PC+8 from M, load data from W (W ALU/PC+8 went via D).
    function automatic logic [2:0] f_efwd(input logic [4:0] src,
                                          input logic [4:0] m_a3, input logic [1:0] m_kind,
                                          input logic [4:0] w_a3, input logic [1:0] w_kind);
        logic [2:0] sel;
        sel = 3'b000;
        if (f_hit(src, m_a3) && m_kind == K_PC8)      sel = 3'b011;
        else if (f_hit(src, m_a3) && m_kind == K_ALU) sel = 3'b010;
        else if (f_hit(src, w_a3) && w_kind == K_MEM) sel = 3'b001;
        return sel;
    endfunction

    assign w_E_Tnew_dec = (r_E_Tnew == 2'd0) ? 2'd0 : r_E_Tnew - 2'd1;

    // Stall and all mux selects, purely from the shadows and the D fields
    always_comb begin
        w_stall = f_hz(D_rs, D_Tuse_rs, r_E_A3, r_E_Tnew, r_M_A3, r_M_Tnew) ||
                  f_hz(D_rt, D_Tuse_rt, r_E_A3, r_E_Tnew, r_M_A3, r_M_Tnew);
        stall   = w_stall;
        MFRD1D  = f_dfwd(D_rs, r_E_A3, r_E_Tnew, r_E_Kind, r_M_A3, r_M_Tnew, r_M_Kind,
                         r_W_A3, r_W_Kind);
        MFRD2D  = f_dfwd(D_rt, r_E_A3, r_E_Tnew, r_E_Kind, r_M_A3, r_M_Tnew, r_M_Kind,
                         r_W_A3, r_W_Kind);
        MFALUAE = f_efwd(r_E_rs, r_M_A3, r_M_Kind, r_W_A3, r_W_Kind);
        MFALUBE = f_efwd(r_E_rt, r_M_A3, r_M_Kind, r_W_A3, r_W_Kind);
        MFWDM   = (f_hit(r_M_rt, r_W_A3) && r_W_Kind == K_MEM) ? 3'b001 : 3'b000;
    end

    // Shadow advance: E takes D (or a bubble on stall), M/W follow, Tnew counts down
    always_ff @(posedge clk) begin
        if (reset) begin
            r_E_A3   <= '0; r_E_Tnew <= '0; r_E_Kind <= '0; r_E_rs <= '0; r_E_rt <= '0;
            r_M_A3   <= '0; r_M_Tnew <= '0; r_M_Kind <= '0; r_M_rt <= '0;
            r_W_A3   <= '0; r_W_Kind <= '0;
        end else begin
            if (w_stall) begin
                r_E_A3 <= '0; r_E_Tnew <= '0; r_E_Kind <= '0; r_E_rs <= '0; r_E_rt <= '0;
            end else begin
                r_E_A3 <= D_A3; r_E_Tnew <= D_Tnew; r_E_Kind <= D_Kind;
                r_E_rs <= D_rs; r_E_rt   <= D_rt;
            end
            r_M_A3   <= r_E_A3;
            r_M_Tnew <= w_E_Tnew_dec;
            r_M_Kind <= r_E_Kind;
            r_M_rt   <= r_E_rt;
            r_W_A3   <= r_M_A3;
            r_W_Kind <= r_M_Kind;
        end
    end

endmodule
